// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: drives an 8-bit camera port (VSYNC/HREF/data) from a stream of RGB565 pixels.
// Latency: a pixel taken while pixel_ready_out is high appears as its high byte the next cycle
//          and as its low byte the cycle after. Every output is registered.
// Backpressure: none towards the line timing. A missing pixel is replaced by FILL_COLOR and
//               flagged on underflow_out.
//
// Ports:
//   p_clock_in        byte clock; all logic runs on its rising edge
//   reset_in          asynchronous active-high reset; forces every output to 0
//   enable_in         lets a new frame start; sampled in IDLE and on the last cycle of a frame
//   pixel_data_in     upstream RGB565 pixel
//   pixel_valid_in    pixel_data_in is valid
//   pixel_ready_out   pixel is taken this cycle (one cycle before its high-byte cycle)
//   vsync_out         high during the VSYNC phase
//   href_out          high while active bytes are on p_data_out
//   p_data_out        byte data; 0 whenever href_out is 0
//   frame_start_out   pulse on the first VSYNC cycle
//   frame_done_out    pulse on the last cycle of the frame
//   underflow_out     sticky: a FILL_COLOR pixel was sent in this frame
module dvp_frame_tx #(
    parameter int          H_ACTIVE     = 320,
    parameter int          V_ACTIVE     = 240,
    parameter int          H_BLANK      = 16,
    parameter int          VSYNC_CYCLES = 3,
    parameter int          V_BACK       = 2,
    parameter int          V_FRONT      = 2,
    parameter logic [15:0] FILL_COLOR   = 16'hF81F
) (
    input  logic        p_clock_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic [15:0] pixel_data_in,
    input  logic        pixel_valid_in,
    output logic        pixel_ready_out,
    output logic        vsync_out,
    output logic        href_out,
    output logic [7:0]  p_data_out,
    output logic        frame_start_out,
    output logic        frame_done_out,
    output logic        underflow_out
);

    localparam int L = 2 * H_ACTIVE + H_BLANK;

    // The horizontal counter also times the VSYNC phase, so it must cover
    // VSYNC_CYCLES as well as a full line.
    localparam int H_MAX  = (L > VSYNC_CYCLES) ? L : VSYNC_CYCLES;
    localparam int V_MAX0 = (V_BACK > V_ACTIVE) ? V_BACK : V_ACTIVE;
    localparam int V_MAX  = (V_MAX0 > V_FRONT) ? V_MAX0 : V_FRONT;
    localparam int HW     = $clog2((H_MAX < 2) ? 2 : H_MAX);
    localparam int VW     = $clog2((V_MAX < 2) ? 2 : V_MAX);

    localparam logic [HW-1:0] H_LAST      = HW'(L - 1);
    localparam logic [HW-1:0] VS_LAST     = HW'(VSYNC_CYCLES - 1);
    localparam logic [HW-1:0] H_ACT_BYTES = HW'(2 * H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_LOW  = HW'(2 * H_ACTIVE - 1);
    localparam logic [VW-1:0] VB_LAST     = VW'((V_BACK  > 0) ? V_BACK  - 1 : 0);
    localparam logic [VW-1:0] VA_LAST     = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST     = VW'((V_FRONT > 0) ? V_FRONT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_BACK,
        S_ACTIVE,
        S_FRONT
    } state_t;

    state_t      state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [15:0] pix_q, pix_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic        fstart_q, fstart_d;
    logic        fdone_q, fdone_d;
    logic        uflow_q, uflow_d;

    logic [15:0] pix_sel;
    logic        low_nxt;
    state_t      after_frame;

    assign after_frame = enable_in ? S_VSYNC : S_IDLE;

    // Next position in the frame. state_q/h_q/v_q describe the cycle whose
    // outputs are currently on the pins.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (enable_in) begin
                    state_d = S_VSYNC;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            S_VSYNC: begin
                if (h_q == VS_LAST) begin
                    h_d     = '0;
                    state_d = (V_BACK > 0) ? S_BACK : S_ACTIVE;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_BACK: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == VB_LAST) begin
                        v_d     = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == VA_LAST) begin
                        v_d     = '0;
                        state_d = (V_FRONT > 0) ? S_FRONT : after_frame;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_FRONT: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == VF_LAST) begin
                        v_d     = '0;
                        state_d = after_frame;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    // Outputs for the next cycle are decoded from the next position so that
    // they can be registered without adding a cycle of skew.
    always_comb begin
        vsync_d  = (state_d == S_VSYNC);
        fstart_d = (state_d == S_VSYNC) && (h_d == '0);
        href_d   = (state_d == S_ACTIVE) && (h_d < H_ACT_BYTES);
        low_nxt  = href_d && h_d[0];

        // Ready in the cycle just before a high-byte cycle: during the low
        // byte of the previous pixel, or on the last cycle before a line's
        // first active byte (end of previous line, BACK, or VSYNC).
        ready_d  = ((state_d == S_ACTIVE) && h_d[0] && (h_d < H_LAST_LOW))
                 | ((state_d == S_ACTIVE) && (h_d == H_LAST) && (v_d != VA_LAST))
                 | ((state_d == S_BACK) && (h_d == H_LAST) && (v_d == VB_LAST))
                 | ((V_BACK == 0) && (state_d == S_VSYNC) && (h_d == VS_LAST));

        fdone_d  = ((state_d == S_FRONT) && (h_d == H_LAST) && (v_d == VF_LAST))
                 | ((V_FRONT == 0) && (state_d == S_ACTIVE) && (h_d == H_LAST)
                    && (v_d == VA_LAST));

        pix_sel  = pixel_valid_in ? pixel_data_in : FILL_COLOR;
        pix_d    = ready_q ? pix_sel : pix_q;

        // The high byte comes straight from the handshake; the low byte is
        // taken from the pixel held since then.
        if (ready_q) begin
            data_d = pix_sel[15:8];
        end else if (low_nxt) begin
            data_d = pix_q[7:0];
        end else begin
            data_d = 8'h00;
        end

        uflow_d = fstart_d ? 1'b0 : (uflow_q | (ready_q & ~pixel_valid_in));
    end

    always_ff @(posedge p_clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            pix_q    <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            fstart_q <= 1'b0;
            fdone_q  <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            pix_q    <= pix_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            fstart_q <= fstart_d;
            fdone_q  <= fdone_d;
            uflow_q  <= uflow_d;
        end
    end

    assign pixel_ready_out = ready_q;
    assign vsync_out       = vsync_q;
    assign href_out        = href_q;
    assign p_data_out      = data_q;
    assign frame_start_out = fstart_q;
    assign frame_done_out  = fdone_q;
    assign underflow_out   = uflow_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// tb_dvp_frame_tx: scoreboard bench for dvp_frame_tx with a small frame geometry.
// Latency: expected pixels are queued at the handshake and compared when their bytes appear.
// Backpressure: stimulus follows pixel_ready_out; valid is sometimes withheld to force fill pixels.
module tb_dvp_frame_tx;

    localparam int H     = 4;
    localparam int VA    = 3;
    localparam int HB    = 2;
    localparam int VS    = 3;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int L     = 2 * H + HB;
    localparam int FRAME = VS + (VB + VA + VF) * L;
    localparam logic [15:0] FILL = 16'hF81F;

    logic        p_clock_in;
    logic        reset_in;
    logic        enable_in;
    logic [15:0] pixel_data_in;
    logic        pixel_valid_in;
    logic        pixel_ready_out;
    logic        vsync_out;
    logic        href_out;
    logic [7:0]  p_data_out;
    logic        frame_start_out;
    logic        frame_done_out;
    logic        underflow_out;

    dvp_frame_tx #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (VA),
        .H_BLANK     (HB),
        .VSYNC_CYCLES(VS),
        .V_BACK      (VB),
        .V_FRONT     (VF),
        .FILL_COLOR  (FILL)
    ) dut (
        .p_clock_in     (p_clock_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .pixel_data_in  (pixel_data_in),
        .pixel_valid_in (pixel_valid_in),
        .pixel_ready_out(pixel_ready_out),
        .vsync_out      (vsync_out),
        .href_out       (href_out),
        .p_data_out     (p_data_out),
        .frame_start_out(frame_start_out),
        .frame_done_out (frame_done_out),
        .underflow_out  (underflow_out)
    );

    initial begin
        p_clock_in = 1'b0;
        forever #5 p_clock_in = ~p_clock_in;
    end

    int n_vec  = 0;
    int n_bad  = 0;
    int mode   = 0;

    typedef struct packed {
        logic [15:0] pix;
        logic        fill;
    } exp_pix_t;

    exp_pix_t sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-position model: m_t is the cycle index inside the current frame.
    bit m_run = 1'b0;
    int m_t   = 0;

    always @(posedge p_clock_in) begin
        if (reset_in) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (enable_in) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (m_t == FRAME - 1) begin
            if (enable_in) m_t = 0;
            else m_run = 1'b0;
        end else begin
            m_t++;
        end
    end

    function automatic bit href_at(input int t);
        int ln, col;
        if (t < VS) return 1'b0;
        ln  = (t - VS) / L;
        col = (t - VS) % L;
        return (ln >= VB) && (ln < VB + VA) && (col < 2 * H);
    endfunction

    function automatic bit hi_at(input int t);
        return href_at(t) && (((t - VS) % L) % 2 == 0);
    endfunction

    // Monitor: compares every cycle against the model, pops the scoreboard
    // on each high-byte cycle.
    initial begin
        bit          exp_uf;
        int          hs_seen;
        int          t;
        logic [15:0] cur;
        exp_pix_t    e;
        exp_uf  = 1'b0;
        hs_seen = 0;
        cur     = '0;
        forever begin
            @(negedge p_clock_in);
            if (reset_in || !m_run) begin
                if (reset_in) exp_uf = 1'b0;
                check("idle_vsync", vsync_out, 0);
                check("idle_href", href_out, 0);
                check("idle_data", p_data_out, 0);
                check("idle_fstart", frame_start_out, 0);
                check("idle_fdone", frame_done_out, 0);
                check("idle_ready", pixel_ready_out, 0);
                check("idle_uflow", underflow_out, exp_uf);
            end else begin
                t = m_t;
                if (t == 0) begin
                    exp_uf  = 1'b0;
                    hs_seen = 0;
                end
                if (hi_at(t)) begin
                    if (sb_q.size() == 0) begin
                        check("sb_empty", 1, 0);
                        cur = '0;
                    end else begin
                        e   = sb_q.pop_front();
                        cur = e.pix;
                        if (e.fill) exp_uf = 1'b1;
                        hs_seen++;
                    end
                    check("byte_hi", p_data_out, cur[15:8]);
                end else if (href_at(t)) begin
                    check("byte_lo", p_data_out, cur[7:0]);
                end else begin
                    check("data_blank", p_data_out, 0);
                end
                check("vsync", vsync_out, (t < VS) ? 1 : 0);
                check("href", href_out, href_at(t) ? 1 : 0);
                check("fstart", frame_start_out, (t == 0) ? 1 : 0);
                check("fdone", frame_done_out, (t == FRAME - 1) ? 1 : 0);
                check("ready", pixel_ready_out, hi_at(t + 1) ? 1 : 0);
                check("uflow", underflow_out, exp_uf);
                if (t == FRAME - 1) check("hs_per_frame", hs_seen, H * VA);
            end
        end
    end

    // Driver: answers each ready with a pixel and queues what must be sent.
    initial begin
        int          hs;
        int          k;
        logic        v;
        logic [15:0] d;
        exp_pix_t    e;
        hs = 0;
        k  = 0;
        pixel_valid_in = 1'b0;
        pixel_data_in  = '0;
        forever begin
            @(negedge p_clock_in);
            if (reset_in) begin
                pixel_valid_in = 1'b0;
                hs = 0;
            end else begin
                if (frame_start_out) hs = 0;
                if (pixel_ready_out) begin
                    d = 16'(32'h1234 + 32'h4444 * k);
                    case (mode)
                        0:       v = 1'b1;
                        1:       v = (hs != 1);
                        default: begin
                            v = ($urandom_range(0, 3) != 0);
                            d = 16'($urandom);
                        end
                    endcase
                    k++;
                    hs++;
                    pixel_valid_in = v;
                    pixel_data_in  = d;
                    e.pix  = v ? d : FILL;
                    e.fill = ~v;
                    sb_q.push_back(e);
                end else begin
                    pixel_valid_in = 1'($urandom_range(0, 1));
                    pixel_data_in  = 16'($urandom);
                end
            end
        end
    end

    initial begin
        int i;
        reset_in  = 1'b1;
        enable_in = 1'b0;
        mode      = 0;
        repeat (3) @(negedge p_clock_in);
        #2 reset_in = 1'b0;

        // Stays idle while disabled.
        repeat (100) @(negedge p_clock_in);
        check("idle_100_vsync", vsync_out, 0);

        // Known pixel sequence, back-to-back frames.
        enable_in = 1'b1;
        repeat (2 * FRAME) @(negedge p_clock_in);

        // Second pixel of each frame withheld.
        mode = 1;
        repeat (2 * FRAME) @(negedge p_clock_in);

        // Random data and random withholding.
        mode = 2;
        repeat (3 * FRAME + 20) @(negedge p_clock_in);

        // Disable mid-frame: current frame finishes, then idle.
        enable_in = 1'b0;
        repeat (FRAME + 20) @(negedge p_clock_in);
        check("idle_after_drop", vsync_out | href_out, 0);

        // Reset in the middle of an active line.
        enable_in = 1'b1;
        i = 0;
        while (!href_out && i < 300) begin
            @(negedge p_clock_in);
            i++;
        end
        check("href_seen", href_out, 1);
        #2 reset_in = 1'b1;
        #1;
        check("rst_href", href_out, 0);
        check("rst_vsync", vsync_out, 0);
        check("rst_data", p_data_out, 0);
        check("rst_ready", pixel_ready_out, 0);
        sb_q.delete();
        repeat (2) @(negedge p_clock_in);
        #2 reset_in = 1'b0;

        // Restart after reset with random traffic.
        repeat (3 * FRAME) @(negedge p_clock_in);
        enable_in = 1'b0;
        repeat (FRAME + 10) @(negedge p_clock_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
